// File: rtl/router_pkg.sv
// Shared router constants and the buffer port arbiter state encoding.
package router_pkg;

    localparam int ADDR_WIDTH    = 10;
    // One packet is NUMBER_PACKET beats; the arbiter grants at most one packet.
    localparam int NUMBER_PACKET = 19;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester after last_owner wins.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    // Scan last_owner+1 .. last_owner+NUM_REQ (mod NUM_REQ) and keep the first hit.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int idx;
            idx = (int'(last_owner) + i) % NUM_REQ;
            if (!valid && req[idx]) begin
                winner = IDX_W'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/buffer_port_arbiter.sv
// Buffer port arbiter: grants one requester at a time for up to one packet of
// buffer beats, in round-robin order, with write taking precedence over read.
//
// Handshake: a requester holds its read_req/write_req high while it wants to
// transfer. The arbiter answers one cycle later with a one-hot gnt that stays
// high for the whole GRANT phase. A beat is transferred on every GRANT cycle in
// which the owner's request for the granted direction is still high (mem_en).
// Dropping the request ends the grant without a beat on that cycle.
module buffer_port_arbiter
    import router_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = router_pkg::ADDR_WIDTH,
    parameter int MAX_BEATS  = router_pkg::NUMBER_PACKET
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            arbiter_read_req,
    input  logic [NUM_REQ-1:0]            arbiter_write_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] arbiter_base_addr,
    output logic [NUM_REQ-1:0]            arbiter_read_gnt,
    output logic [NUM_REQ-1:0]            arbiter_write_gnt,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          arbiter_busy,
    output logic [1:0]                    fsm_state
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    arb_state_t              state;
    logic [IDX_W-1:0]        owner;
    logic [IDX_W-1:0]        last_owner;
    logic                    dir_write;
    logic [ADDR_WIDTH-1:0]   base;
    logic [BEAT_W-1:0]       beat_cnt;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_valid;
    logic                    owner_req;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (arbiter_read_req | arbiter_write_req),
        .last_owner (last_owner),
        .winner     (pick_idx),
        .valid      (pick_valid)
    );

    // Owner's live request for the latched direction gates each beat.
    always_comb begin
        owner_req = dir_write ? arbiter_write_req[owner] : arbiter_read_req[owner];
        mem_en    = (state == ST_GRANT) && owner_req;
        mem_we    = (state == ST_GRANT) && dir_write;
        mem_addr  = (state == ST_GRANT) ? (base + ADDR_WIDTH'(beat_cnt)) : '0;
    end

    assign arbiter_busy = (state != ST_IDLE);
    assign fsm_state    = state;

    // Arbitration FSM with registered grants and latched owner context.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            owner             <= '0;
            last_owner        <= IDX_W'(NUM_REQ - 1);
            dir_write         <= 1'b0;
            base              <= '0;
            beat_cnt          <= '0;
            arbiter_read_gnt  <= '0;
            arbiter_write_gnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner     <= pick_idx;
                        dir_write <= arbiter_write_req[pick_idx];
                        base      <= arbiter_base_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        beat_cnt  <= '0;
                        if (arbiter_write_req[pick_idx]) begin
                            arbiter_write_gnt <= NUM_REQ'(1) << pick_idx;
                        end else begin
                            arbiter_read_gnt <= NUM_REQ'(1) << pick_idx;
                        end
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!owner_req || (beat_cnt == BEAT_W'(MAX_BEATS - 1))) begin
                        // Final beat (if any) happens this cycle; grant ends at the edge.
                        arbiter_read_gnt  <= '0;
                        arbiter_write_gnt <= '0;
                        state             <= ST_RELEASE;
                    end
                    if (owner_req) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    last_owner <= owner;
                    state      <= ST_IDLE;
                end
                default: begin
                    arbiter_read_gnt  <= '0;
                    arbiter_write_gnt <= '0;
                    state             <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_port_arbiter.sv
// Directed bench for buffer_port_arbiter: each task drives one scenario and
// compares outputs against hand-computed values at the falling clock edge.
module tb_buffer_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int AW      = 10;
    localparam int BEATS   = 19;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    read_req;
    logic [NUM_REQ-1:0]    write_req;
    logic [NUM_REQ*AW-1:0] base_addr;
    logic [NUM_REQ-1:0]    read_gnt;
    logic [NUM_REQ-1:0]    write_gnt;
    logic                  mem_en;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic                  busy;
    logic [1:0]            fsm_state;

    int checks = 0;
    int errors = 0;

    buffer_port_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (AW),
        .MAX_BEATS  (BEATS)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .arbiter_read_req  (read_req),
        .arbiter_write_req (write_req),
        .arbiter_base_addr (base_addr),
        .arbiter_read_gnt  (read_gnt),
        .arbiter_write_gnt (write_gnt),
        .mem_en            (mem_en),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .arbiter_busy      (busy),
        .fsm_state         (fsm_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic set_base(input int idx, input logic [AW-1:0] val);
        base_addr[idx*AW +: AW] = val;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        read_req  = '0;
        write_req = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        read_req  = '0;
        write_req = '0;
        base_addr = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({read_gnt, write_gnt} !== 8'h00) begin
            errors++;
            $display("FAIL reset_gnt: actual %h required 00", {read_gnt, write_gnt});
        end
        checks++;
        if ({mem_en, mem_we, busy} !== 3'b000 || mem_addr !== 10'h000) begin
            errors++;
            $display("FAIL reset_mem: actual en=%b we=%b busy=%b addr=%h required 0", mem_en, mem_we, busy, mem_addr);
        end
        checks++;
        if (fsm_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: actual %0d required 0", fsm_state);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fsm_state !== 2'd0) begin
            errors++;
            $display("FAIL idle_after_reset: actual busy=%b state=%0d required 0/0", busy, fsm_state);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        set_base(0, 10'h010);
        read_req = 4'b0001;
        for (int b = 0; b < BEATS; b++) begin
            @(negedge clk);
            checks++;
            if (read_gnt !== 4'b0001 || write_gnt !== 4'b0000) begin
                errors++;
                $display("FAIL single_gnt beat %0d: actual r=%b w=%b required r=0001 w=0000", b, read_gnt, write_gnt);
            end
            checks++;
            if (mem_en !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL single_ctrl beat %0d: actual en=%b we=%b busy=%b required 1/0/1", b, mem_en, mem_we, busy);
            end
            checks++;
            if (mem_addr !== 10'(10'h010 + b)) begin
                errors++;
                $display("FAIL single_addr beat %0d: actual %h required %h", b, mem_addr, 10'(10'h010 + b));
            end
        end
        @(negedge clk);
        checks++;
        if (read_gnt !== 4'b0000 || mem_en !== 1'b0 || busy !== 1'b1 || fsm_state !== 2'd2) begin
            errors++;
            $display("FAIL single_release: actual gnt=%b en=%b busy=%b state=%0d required 0000/0/1/2", read_gnt, mem_en, busy, fsm_state);
        end
        read_req = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fsm_state !== 2'd0) begin
            errors++;
            $display("FAIL single_idle: actual busy=%b state=%0d required 0/0", busy, fsm_state);
        end
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_base(i, 10'(i * 'h40 + 5));
        write_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int b = 0; b < BEATS; b++) begin
                @(negedge clk);
                checks++;
                if (write_gnt !== 4'(1 << order[k]) || read_gnt !== 4'b0000 || mem_we !== 1'b1 || mem_en !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_gnt grant %0d beat %0d: actual w=%b r=%b we=%b en=%b required w=%b r=0000 we=1 en=1",
                             k, b, write_gnt, read_gnt, mem_we, mem_en, 4'(1 << order[k]));
                end
                checks++;
                if (mem_addr !== 10'(order[k] * 'h40 + 5 + b)) begin
                    errors++;
                    $display("FAIL rr_addr grant %0d beat %0d: actual %h required %h", k, b, mem_addr, 10'(order[k] * 'h40 + 5 + b));
                end
            end
            @(negedge clk);
            checks++;
            if (write_gnt !== 4'b0000 || mem_en !== 1'b0 || fsm_state !== 2'd2) begin
                errors++;
                $display("FAIL rr_release grant %0d: actual gnt=%b en=%b state=%0d required 0000/0/2", k, write_gnt, mem_en, fsm_state);
            end
            if (k == 4) write_req = '0;
            @(negedge clk);
            checks++;
            if (write_gnt !== 4'b0000 || busy !== 1'b0 || mem_addr !== 10'h000) begin
                errors++;
                $display("FAIL rr_idle grant %0d: actual gnt=%b busy=%b addr=%h required 0000/0/000", k, write_gnt, busy, mem_addr);
            end
        end
    endtask

    task automatic test_write_priority();
        do_reset();
        set_base(2, 10'h100);
        read_req  = 4'b0100;
        write_req = 4'b0100;
        @(negedge clk);
        checks++;
        if (write_gnt !== 4'b0100 || read_gnt !== 4'b0000) begin
            errors++;
            $display("FAIL prio_gnt: actual w=%b r=%b required w=0100 r=0000", write_gnt, read_gnt);
        end
        checks++;
        if (mem_we !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 10'h100) begin
            errors++;
            $display("FAIL prio_mem: actual we=%b en=%b addr=%h required 1/1/100", mem_we, mem_en, mem_addr);
        end
        // Dropping only the read request must not end a write grant.
        read_req = 4'b0000;
        @(negedge clk);
        checks++;
        if (write_gnt !== 4'b0100 || mem_en !== 1'b1 || mem_addr !== 10'h101) begin
            errors++;
            $display("FAIL prio_read_drop: actual w=%b en=%b addr=%h required 0100/1/101", write_gnt, mem_en, mem_addr);
        end
        write_req = 4'b0000;
        @(negedge clk);
        checks++;
        if (fsm_state !== 2'd2 || write_gnt !== 4'b0000 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL prio_release: actual state=%0d w=%b we=%b required 2/0000/0", fsm_state, write_gnt, mem_we);
        end
        @(negedge clk);
    endtask

    task automatic test_early_drop();
        do_reset();
        set_base(1, 10'h200);
        read_req = 4'b0010;
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            checks++;
            if (mem_en !== 1'b1 || mem_addr !== 10'(10'h200 + b) || read_gnt !== 4'b0010) begin
                errors++;
                $display("FAIL drop_beat %0d: actual en=%b addr=%h gnt=%b required 1/%h/0010", b, mem_en, mem_addr, read_gnt, 10'(10'h200 + b));
            end
        end
        @(negedge clk);
        read_req = 4'b0000;
        #1;
        checks++;
        if (mem_en !== 1'b0 || fsm_state !== 2'd1 || read_gnt !== 4'b0010) begin
            errors++;
            $display("FAIL drop_cycle: actual en=%b state=%0d gnt=%b required 0/1/0010", mem_en, fsm_state, read_gnt);
        end
        checks++;
        if (mem_addr !== 10'h205) begin
            errors++;
            $display("FAIL drop_beats: actual addr=%h required 205 (5 beats)", mem_addr);
        end
        @(negedge clk);
        checks++;
        if (fsm_state !== 2'd2 || read_gnt !== 4'b0000 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL drop_release: actual state=%0d gnt=%b en=%b required 2/0000/0", fsm_state, read_gnt, mem_en);
        end
        @(negedge clk);
    endtask

    task automatic test_addr_wrap();
        logic [AW-1:0] exp_addr;
        do_reset();
        set_base(0, 10'h3FD);
        read_req = 4'b0001;
        exp_addr = 10'h3FD;
        for (int b = 0; b < BEATS; b++) begin
            @(negedge clk);
            // Base changes mid-grant must not move the address stream.
            set_base(0, 10'h155);
            checks++;
            if (mem_addr !== exp_addr) begin
                errors++;
                $display("FAIL wrap_addr beat %0d: actual %h required %h", b, mem_addr, exp_addr);
            end
            exp_addr = exp_addr + 10'd1;
        end
        @(negedge clk);
        read_req = '0;
        checks++;
        if (fsm_state !== 2'd2 || mem_addr !== 10'h000) begin
            errors++;
            $display("FAIL wrap_release: actual state=%0d addr=%h required 2/000", fsm_state, mem_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        set_base(0, 10'h050);
        set_base(1, 10'h060);
        read_req = 4'b0001;
        @(negedge clk);
        read_req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        read_req = 4'b0010;
        for (int b = 0; b <= 7; b++) begin
            @(negedge clk);
            checks++;
            if (read_gnt !== 4'b0010 || mem_addr !== 10'(10'h060 + b)) begin
                errors++;
                $display("FAIL rstmid_beat %0d: actual gnt=%b addr=%h required 0010/%h", b, read_gnt, mem_addr, 10'(10'h060 + b));
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({read_gnt, write_gnt} !== 8'h00 || {mem_en, mem_we, busy} !== 3'b000 || mem_addr !== 10'h000 || fsm_state !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: actual gnt=%h en=%b we=%b busy=%b addr=%h state=%0d required all 0",
                     {read_gnt, write_gnt}, mem_en, mem_we, busy, mem_addr, fsm_state);
        end
        rst_n    = 1'b1;
        read_req = 4'b0011;
        @(negedge clk);
        checks++;
        if (read_gnt !== 4'b0001 || mem_addr !== 10'h050) begin
            errors++;
            $display("FAIL rstmid_priority: actual gnt=%b addr=%h required 0001/050", read_gnt, mem_addr);
        end
        read_req = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        read_req  = '0;
        write_req = '0;
        base_addr = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_priority();
        test_early_drop();
        test_addr_wrap();
        test_reset_mid_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/buffer_port_arbiter.md
BUFFER_PORT_ARBITER -- requirements
Module: buffer_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requester slots (router controllers).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, buffer address width.
REQ-003 SHALL have parameter MAX_BEATS, default 19, maximum beats per grant (one packet).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port arbiter_read_req  input  NUM_REQ  per-requester read request.
REQ-007 SHALL have port arbiter_write_req  input  NUM_REQ  per-requester write request.
REQ-008 SHALL have port arbiter_base_addr  input  NUM_REQ*ADDR_WIDTH  packed per-requester start address; slot i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have port arbiter_read_gnt  output  NUM_REQ  one-hot read grant.
REQ-010 SHALL have port arbiter_write_gnt  output  NUM_REQ  one-hot write grant.
REQ-011 SHALL have port mem_en  output  1  buffer access strobe.
REQ-012 SHALL have port mem_we  output  1  1 = write, 0 = read; valid only while mem_en = 1.
REQ-013 SHALL have port mem_addr  output  ADDR_WIDTH  buffer address for the current beat.
REQ-014 SHALL have port arbiter_busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, GRANT, RELEASE; any other encoding SHALL return to IDLE.
REQ-016 IDLE: if any request bit is high, SHALL pick the owner, latch owner index, direction and base address, and go to GRANT; otherwise stay in IDLE.
REQ-017 Owner selection SHALL be round-robin: search starts at last_owner+1 and wraps modulo NUM_REQ.
REQ-018 For a selected requester with both read_req and write_req high, write SHALL win for that grant.
REQ-019 Grant latency SHALL be exactly 1 cycle: request sampled high in IDLE means gnt is high the next cycle.
REQ-020 GRANT: only the owner's gnt bit for the latched direction SHALL be high; all other gnt bits SHALL be 0.
REQ-021 GRANT: mem_en SHALL equal the owner's current request bit for the latched direction (combinational gate), so no access occurs on the drop cycle.
REQ-022 GRANT: mem_we SHALL equal the latched direction.
REQ-023 GRANT: mem_addr SHALL equal latched base + beat_cnt, modulo 2^ADDR_WIDTH; e.g. base 0x3FE with beat 3 gives 0x001.
REQ-024 beat_cnt SHALL clear on entry to GRANT and increment by 1 on each cycle with mem_en = 1.
REQ-025 GRANT SHALL exit to RELEASE when the owner's request is sampled low, or when mem_en = 1 and beat_cnt = MAX_BEATS-1 (the final beat is still performed).
REQ-026 RELEASE SHALL last exactly 1 cycle, with all gnt = 0 and mem_en = 0; it SHALL update last_owner to the owner, then go to IDLE.
REQ-027 Back-to-back: a requester still requesting after RELEASE SHALL be reconsidered in IDLE behind the round-robin order; minimum gap between grants is 2 cycles (RELEASE + IDLE).
REQ-028 Request changes of non-owners during GRANT SHALL be ignored until IDLE.
REQ-029 Changes to arbiter_base_addr during GRANT SHALL NOT affect mem_addr.
REQ-030 Outside GRANT: mem_en = 0, mem_we = 0, mem_addr = 0.

Reset
REQ-031 On rst_n = 0 sampled at a clock edge: state = IDLE; all gnt, mem_en, mem_we, mem_addr, arbiter_busy and beat_cnt = 0; last_owner = NUM_REQ-1, so requester 0 has first priority.
REQ-032 Reset asserted mid-GRANT SHALL drop the grant and mem_en at that same edge, with no RELEASE cycle.

Structure
REQ-033 Shared package router_pkg SHALL hold ADDR_WIDTH, NUMBER_PACKET (used as the MAX_BEATS default) and the arbiter state encoding.
REQ-034 The round-robin search SHALL be a sub-module rr_pick (inputs: request vector, last_owner; outputs: winner index, valid); it SHALL be purely combinational.

Verification
REQ-035 After reset, read_req = 4'b0001, base[0] = 0x010, held for 25 cycles -> read_gnt = 4'b0001 from cycle 1; mem_addr = 0x010..0x022 (19 beats); then 1 RELEASE cycle with gnt = 0.
REQ-036 Requesters 0..3 all raise write_req together and hold it -> grant order 0, 1, 2, 3, 0; each grant lasts 19 beats.
REQ-037 Requester 2 sets read_req and write_req both high -> write_gnt = 4'b0100, read_gnt = 0, mem_we = 1.
REQ-038 Owner drops its request after 5 beats -> mem_en = 0 on the drop cycle; beats = 5; RELEASE follows on the next cycle.
REQ-039 base = 0x3FD, 19-beat read -> mem_addr sequence 0x3FD, 0x3FE, 0x3FF, 0x000 ... 0x00F.
REQ-040 rst_n driven low during beat 7 of a grant -> next cycle all outputs = 0 and state = IDLE; after release, requester 0 has first priority again.
